// File: rtl/timer_bus_if.sv
// Register-bus link between the CPU's M-stage address decoder and the timer device.
// TIMER_BYTE_WRITE_EN adds the byte-enable lane used by sb/sh stores.
interface timer_bus_if;
    logic [1:0]  addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
`ifdef TIMER_BYTE_WRITE_EN
    logic [3:0]  be;

    modport master (output addr, we, wdata, be, input rdata);
    modport slave  (input addr, we, wdata, be, output rdata);
`else
    modport master (output addr, we, wdata, input rdata);
    modport slave  (input addr, we, wdata, output rdata);
`endif
endinterface

// File: rtl/timer_dev.sv
// Memory-mapped countdown timer (CTRL/PRESET/COUNT) with one-shot and auto-reload modes.
// Optional byte-lane writes when TIMER_BYTE_WRITE_EN is defined.
module timer_dev #(
    parameter int CNT_W    = 32,
    parameter int PRESCALE = 1
) (
    input  logic        clk,
    input  logic        reset,
    timer_bus_if.slave  bus,
    output logic        irq,
    output logic [1:0]  dbg_state
);
    // Bus semantics: a write is taken on every rising clk edge where we=1;
    // rdata is a pure combinational function of addr and the registers.

    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, CNT = 2'd2, INT = 2'd3} state_t;

    state_t            state;
    logic [3:0]        ctrl;
    logic [CNT_W-1:0]  preset;
    logic [CNT_W-1:0]  count;
    logic [PS_W-1:0]   prescaler;
    logic              pending;

    logic [31:0]       ctrl_new;
    logic [31:0]       preset_new;
    logic              wr_en;
    logic              tick;
    logic              reload_mode;
    logic              set_pend;
    logic              clr_pend;

`ifdef TIMER_BYTE_WRITE_EN
    // Unselected byte lanes keep the register's current contents.
    always_comb begin
        ctrl_new   = {28'd0, ctrl};
        preset_new = 32'(preset);
        for (int i = 0; i < 4; i++) begin
            if (bus.be[i]) begin
                ctrl_new[8*i +: 8]   = bus.wdata[8*i +: 8];
                preset_new[8*i +: 8] = bus.wdata[8*i +: 8];
            end
        end
    end
    assign wr_en = bus.we && (bus.be != 4'd0);
`else
    assign ctrl_new   = bus.wdata;
    assign preset_new = bus.wdata;
    assign wr_en      = bus.we;
`endif

    assign tick        = (prescaler == PS_W'(PRESCALE - 1));
    assign reload_mode = (ctrl[2:1] == 2'b01);
    assign set_pend    = (state == CNT) && ctrl[0] && tick && (count <= CNT_W'(1));
    assign clr_pend    = (wr_en && (bus.addr == 2'd0 || bus.addr == 2'd1)) ||
                         ((state == INT) && reload_mode);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            ctrl      <= 4'd0;
            preset    <= '0;
            count     <= '0;
            prescaler <= '0;
            pending   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (ctrl[0]) state <= LOAD;
                LOAD: begin
                    count     <= preset;
                    prescaler <= '0;
                    state     <= CNT;
                end
                CNT: begin
                    if (!ctrl[0]) begin
                        state <= IDLE;
                    end else if (tick) begin
                        prescaler <= '0;
                        if (count > CNT_W'(1)) begin
                            count <= count - CNT_W'(1);
                        end else begin
                            count <= '0;
                            state <= INT;
                        end
                    end else begin
                        prescaler <= prescaler + PS_W'(1);
                    end
                end
                INT: begin
                    if (reload_mode) begin
                        state <= LOAD;
                    end else begin
                        ctrl[0] <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // CPU writes come after the FSM so they override its EN clear.
            if (wr_en && bus.addr == 2'd0) ctrl   <= ctrl_new[3:0];
            if (wr_en && bus.addr == 2'd1) preset <= preset_new[CNT_W-1:0];

            // Expiry set has priority over any clear in the same cycle.
            if (set_pend)      pending <= 1'b1;
            else if (clr_pend) pending <= 1'b0;
        end
    end

    always_comb begin
        bus.rdata = 32'd0;
        case (bus.addr)
            2'd0:    bus.rdata = {28'd0, ctrl};
            2'd1:    bus.rdata = 32'(preset);
            2'd2:    bus.rdata = 32'(count);
            default: bus.rdata = 32'd0;
        endcase
    end

    assign irq       = pending & ctrl[3];
    assign dbg_state = state;
endmodule

// File: tb/tb_timer_dev.sv
// Directed bench for timer_dev: instance A (PRESCALE=1) and instance B (PRESCALE=3).
// Byte-lane cases run only when TIMER_BYTE_WRITE_EN is defined.
module tb_timer_dev;
    logic       clk;
    logic       reset_a;
    logic       reset_b;
    logic       irq_a;
    logic       irq_b;
    logic [1:0] state_a;
    logic [1:0] state_b;

    int n_pass  = 0;
    int n_total = 0;

    timer_bus_if bus_a ();
    timer_bus_if bus_b ();

    timer_dev #(.CNT_W(32), .PRESCALE(1)) dut_a (
        .clk(clk), .reset(reset_a), .bus(bus_a), .irq(irq_a), .dbg_state(state_a)
    );

    timer_dev #(.CNT_W(32), .PRESCALE(3)) dut_b (
        .clk(clk), .reset(reset_b), .bus(bus_b), .irq(irq_b), .dbg_state(state_b)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    // All drivers are called at a falling edge; the write lands on the next rising edge.
    task automatic wr(input bit sel, input logic [1:0] a, input logic [31:0] d, input logic [3:0] b);
        if (sel) begin
            bus_b.addr = a; bus_b.wdata = d; bus_b.we = 1'b1;
`ifdef TIMER_BYTE_WRITE_EN
            bus_b.be = b;
`endif
        end else begin
            bus_a.addr = a; bus_a.wdata = d; bus_a.we = 1'b1;
`ifdef TIMER_BYTE_WRITE_EN
            bus_a.be = b;
`endif
        end
        @(negedge clk);
        bus_a.we = 1'b0;
        bus_b.we = 1'b0;
`ifndef TIMER_BYTE_WRITE_EN
        if (b == 4'd0) $display("note: zero byte-enable ignored in full-word build");
`endif
    endtask

    task automatic rd_chk(input bit sel, input logic [1:0] a, input logic [31:0] exp, input string tag);
        if (sel) bus_b.addr = a;
        else     bus_a.addr = a;
        #1;
        check(tag, sel ? bus_b.rdata : bus_a.rdata, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    localparam logic [3:0] FULL = 4'hF;

    // auto-reload expectations for edges 1..9 after the enabling write
    logic [1:0]  ar_state [1:9] = '{2'd1, 2'd2, 2'd2, 2'd3, 2'd1, 2'd2, 2'd2, 2'd3, 2'd1};
    logic        ar_irq   [1:9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [31:0] ar_cnt   [2:8] = '{32'd2, 32'd1, 32'd0, 32'd0, 32'd2, 32'd1, 32'd0};
    // PRESCALE=3, PRESET=2: COUNT at edges 3..8 after the enabling write
    logic [31:0] ps_cnt   [3:8] = '{32'd2, 32'd2, 32'd1, 32'd1, 32'd1, 32'd0};

    initial begin
        bus_a.addr = 2'd0; bus_a.we = 1'b0; bus_a.wdata = 32'd0;
        bus_b.addr = 2'd0; bus_b.we = 1'b0; bus_b.wdata = 32'd0;
`ifdef TIMER_BYTE_WRITE_EN
        bus_a.be = FULL; bus_b.be = FULL;
`endif
        reset_a = 1'b1;
        reset_b = 1'b1;
        step(3);
        reset_a = 1'b0;
        reset_b = 1'b0;

        // 1: reset state, COUNT is read-only
        rd_chk(0, 2'd0, 32'd0, "rst_ctrl");
        rd_chk(0, 2'd1, 32'd0, "rst_preset");
        rd_chk(0, 2'd2, 32'd0, "rst_count");
        check("rst_irq", {31'd0, irq_a}, 32'd0);
        check("rst_state", {30'd0, state_a}, 32'd0);
        wr(0, 2'd2, 32'd5, FULL);
        rd_chk(0, 2'd2, 32'd0, "count_ro");
        wr(0, 2'd3, 32'hFFFF_FFFF, FULL);
        rd_chk(0, 2'd3, 32'd0, "rsvd_rd");
        wr(0, 2'd0, 32'hFFFF_FFF6, FULL);
        rd_chk(0, 2'd0, 32'h6, "ctrl_upper0");
        wr(0, 2'd0, 32'd0, FULL);

        // 2: one-shot, PRESET=3
        wr(0, 2'd1, 32'd3, FULL);
        rd_chk(0, 2'd1, 32'd3, "preset_rd");
        wr(0, 2'd0, 32'h9, FULL);
        step(1);
        check("os_load", {30'd0, state_a}, 32'd1);
        step(1);
        rd_chk(0, 2'd2, 32'd3, "os_cnt3");
        step(1);
        rd_chk(0, 2'd2, 32'd2, "os_cnt2");
        step(1);
        rd_chk(0, 2'd2, 32'd1, "os_cnt1");
        check("os_irq_lo", {31'd0, irq_a}, 32'd0);
        step(1);
        rd_chk(0, 2'd2, 32'd0, "os_cnt0");
        check("os_irq_hi", {31'd0, irq_a}, 32'd1);
        check("os_int", {30'd0, state_a}, 32'd3);
        step(1);
        check("os_idle", {30'd0, state_a}, 32'd0);
        rd_chk(0, 2'd0, 32'h8, "os_ctrl8");
        step(2);
        check("os_irq_held", {31'd0, irq_a}, 32'd1);
        rd_chk(0, 2'd2, 32'd0, "os_no_wrap");
        wr(0, 2'd0, 32'd0, FULL);
        check("os_irq_clr", {31'd0, irq_a}, 32'd0);

        // 3: auto-reload, PRESET=2
        wr(0, 2'd1, 32'd2, FULL);
        wr(0, 2'd0, 32'hB, FULL);
        bus_a.addr = 2'd2;
        for (int k = 1; k <= 9; k++) begin
            step(1);
            #1;
            check($sformatf("ar_state%0d", k), {30'd0, state_a}, {30'd0, ar_state[k]});
            check($sformatf("ar_irq%0d", k), {31'd0, irq_a}, {31'd0, ar_irq[k]});
            if (k >= 2 && k <= 8)
                check($sformatf("ar_cnt%0d", k), bus_a.rdata, ar_cnt[k]);
        end
        wr(0, 2'd0, 32'd0, FULL);

        // 4: disable mid-count holds COUNT, re-enable reloads
        wr(0, 2'd1, 32'd4, FULL);
        wr(0, 2'd0, 32'h9, FULL);
        step(2);
        rd_chk(0, 2'd2, 32'd4, "dis_cnt4");
        step(1);
        rd_chk(0, 2'd2, 32'd3, "dis_cnt3");
        wr(0, 2'd0, 32'h8, FULL);
        rd_chk(0, 2'd2, 32'd2, "dis_cnt2");
        step(1);
        check("dis_idle", {30'd0, state_a}, 32'd0);
        rd_chk(0, 2'd2, 32'd2, "dis_hold");
        step(2);
        rd_chk(0, 2'd2, 32'd2, "dis_hold2");
        check("dis_noirq", {31'd0, irq_a}, 32'd0);
        wr(0, 2'd0, 32'h9, FULL);
        step(2);
        rd_chk(0, 2'd2, 32'd4, "re_load4");
        check("re_cnt", {30'd0, state_a}, 32'd2);
        wr(0, 2'd0, 32'd0, FULL);

        // 5: PRESCALE=3 on instance B, then reset mid-count
        wr(1, 2'd1, 32'd2, FULL);
        wr(1, 2'd0, 32'h9, FULL);
        step(2);
        rd_chk(1, 2'd2, 32'd2, "ps_load");
        for (int k = 3; k <= 8; k++) begin
            step(1);
            rd_chk(1, 2'd2, ps_cnt[k], $sformatf("ps_cnt%0d", k));
        end
        check("ps_irq", {31'd0, irq_b}, 32'd1);
        step(1);
        wr(1, 2'd0, 32'h9, FULL);
        check("ps_irq_clr", {31'd0, irq_b}, 32'd0);
        step(5);
        rd_chk(1, 2'd2, 32'd1, "ps_pre_rst");
        reset_b = 1'b1;
        rd_chk(1, 2'd0, 32'd0, "ps_rst_ctrl");
        rd_chk(1, 2'd1, 32'd0, "ps_rst_preset");
        rd_chk(1, 2'd2, 32'd0, "ps_rst_count");
        check("ps_rst_irq", {31'd0, irq_b}, 32'd0);
        check("ps_rst_state", {30'd0, state_b}, 32'd0);
        step(1);
        reset_b = 1'b0;
        step(8);
        check("ps_rst_noirq", {31'd0, irq_b}, 32'd0);

        // 6: byte-lane writes
        wr(0, 2'd0, 32'd0, FULL);
        wr(0, 2'd1, 32'd0, FULL);
`ifdef TIMER_BYTE_WRITE_EN
        wr(0, 2'd0, 32'hFFFF_FF09, 4'b0001);
        rd_chk(0, 2'd0, 32'h9, "be_ctrl");
        wr(0, 2'd1, 32'hAABB_CCDD, 4'b1100);
        rd_chk(0, 2'd1, 32'hAABB_0000, "be_preset");
        wr(0, 2'd0, 32'd0, FULL);
        wr(0, 2'd0, 32'h0000_0009, 4'b0000);
        rd_chk(0, 2'd0, 32'h0, "be_none");
`else
        wr(0, 2'd1, 32'hAABB_CCDD, FULL);
        rd_chk(0, 2'd1, 32'hAABB_CCDD, "full_preset");
        wr(0, 2'd0, 32'hFFFF_FF08, FULL);
        rd_chk(0, 2'd0, 32'h8, "full_ctrl");
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
